// File: rtl/tx_control_fsm.sv
// tx_control_fsm: transmission-layer control FSM for bring-up, FIFO threshold
// distribution, activity tracking and sticky error capture.
module tx_control_fsm #(
    parameter int FIFO_DEPTH   = 8,
    parameter int UMBRAL_WIDTH = 4,
    parameter int IDLE_CYCLES  = 2
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic                    init,
    input  logic [UMBRAL_WIDTH-1:0] Umbral_VC0_in,
    input  logic [UMBRAL_WIDTH-1:0] Umbral_VC1_in,
    input  logic [UMBRAL_WIDTH-1:0] Umbral_D0_in,
    input  logic [UMBRAL_WIDTH-1:0] Umbral_D1_in,
    input  logic                    empty_fifo_VC0,
    input  logic                    empty_fifo_VC1,
    input  logic                    empty_fifo_D0,
    input  logic                    empty_fifo_D1,
    input  logic                    error_VC0,
    input  logic                    error_VC1,
    input  logic                    error_D0,
    input  logic                    error_D1,
    output logic [2:0]              state,
    output logic                    init_fifo,
    output logic                    idle_out,
    output logic                    active_out,
    output logic                    error_out,
    output logic [3:0]              error_src,
    output logic [UMBRAL_WIDTH-1:0] Umbral_VC0,
    output logic [UMBRAL_WIDTH-1:0] Umbral_VC1,
    output logic [UMBRAL_WIDTH-1:0] Umbral_D0,
    output logic [UMBRAL_WIDTH-1:0] Umbral_D1
);
    typedef enum logic [2:0] {
        RESET  = 3'b000,
        INIT   = 3'b001,
        IDLE   = 3'b010,
        ACTIVE = 3'b011,
        ERROR  = 3'b100
    } state_t;

    localparam logic [UMBRAL_WIDTH-1:0] UMB_MAX = UMBRAL_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [3:0]              IDLE_N  = 4'(IDLE_CYCLES);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [3:0]              error_src_q, error_src_d;
    logic [UMBRAL_WIDTH-1:0] umb_q [4];
    logic [UMBRAL_WIDTH-1:0] umb_d [4];
    logic [UMBRAL_WIDTH-1:0] umb_in [4];
    logic                    init_fifo_q, idle_q, active_q, error_q;
    logic [3:0]              errs;
    logic                    any_err, all_empty;

    assign umb_in    = '{Umbral_VC0_in, Umbral_VC1_in, Umbral_D0_in, Umbral_D1_in};
    assign errs      = {error_D1, error_D0, error_VC1, error_VC0};
    assign any_err   = |errs;
    assign all_empty = empty_fifo_VC0 & empty_fifo_VC1 & empty_fifo_D0 & empty_fifo_D1;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            RESET:  state_d = INIT;
            INIT:   state_d = init ? INIT : IDLE;
            IDLE:   state_d = any_err ? ERROR : init ? INIT : !all_empty ? ACTIVE : IDLE;
            ACTIVE: begin
                cnt_d   = all_empty ? cnt_q + 4'd1 : 4'd0;
                state_d = any_err ? ERROR : init ? INIT
                        : (all_empty && cnt_d == IDLE_N) ? IDLE : ACTIVE;
            end
            ERROR:  state_d = init ? INIT : ERROR;
            default: state_d = RESET;
        endcase
        if (state_d != ACTIVE) cnt_d = '0;
        // Sticky sources accumulate only while heading into or staying in ERROR
        error_src_d = (state_d == ERROR) ? (error_src_q | errs)
                    : (state_d == INIT || state_d == RESET) ? 4'd0 : error_src_q;
        for (int i = 0; i < 4; i++)
            umb_d[i] = (state_q == INIT) ? ((umb_in[i] > UMB_MAX) ? UMB_MAX : umb_in[i])
                     : (state_d == RESET) ? '0 : umb_q[i];
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= RESET;
            cnt_q       <= '0;
            error_src_q <= '0;
            umb_q       <= '{default: '0};
            init_fifo_q <= 1'b0;
            idle_q      <= 1'b0;
            active_q    <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            error_src_q <= error_src_d;
            umb_q       <= umb_d;
            init_fifo_q <= (state_d == INIT);
            idle_q      <= (state_d == IDLE);
            active_q    <= (state_d == ACTIVE);
            error_q     <= (state_d == ERROR);
        end
    end

    assign state      = state_q;
    assign init_fifo  = init_fifo_q;
    assign idle_out   = idle_q;
    assign active_out = active_q;
    assign error_out  = error_q;
    assign error_src  = error_src_q;
    assign Umbral_VC0 = umb_q[0];
    assign Umbral_VC1 = umb_q[1];
    assign Umbral_D0  = umb_q[2];
    assign Umbral_D1  = umb_q[3];
endmodule

// File: tb/tb_tx_control_fsm.sv
// tb_tx_control_fsm: directed scenario tests for tx_control_fsm with
// hand-computed expected values.
module tb_tx_control_fsm;
    logic       clk = 1'b0;
    logic       reset_L, init;
    logic [3:0] u_vc0_in, u_vc1_in, u_d0_in, u_d1_in;
    logic       e_vc0, e_vc1, e_d0, e_d1;
    logic       er_vc0, er_vc1, er_d0, er_d1;
    logic [2:0] state;
    logic       init_fifo, idle_out, active_out, error_out;
    logic [3:0] error_src, u_vc0, u_vc1, u_d0, u_d1;
    int         vectors = 0;
    int         miscompares = 0;

    tx_control_fsm dut (
        .clk(clk), .reset_L(reset_L), .init(init),
        .Umbral_VC0_in(u_vc0_in), .Umbral_VC1_in(u_vc1_in),
        .Umbral_D0_in(u_d0_in), .Umbral_D1_in(u_d1_in),
        .empty_fifo_VC0(e_vc0), .empty_fifo_VC1(e_vc1),
        .empty_fifo_D0(e_d0), .empty_fifo_D1(e_d1),
        .error_VC0(er_vc0), .error_VC1(er_vc1), .error_D0(er_d0), .error_D1(er_d1),
        .state(state), .init_fifo(init_fifo), .idle_out(idle_out),
        .active_out(active_out), .error_out(error_out), .error_src(error_src),
        .Umbral_VC0(u_vc0), .Umbral_VC1(u_vc1), .Umbral_D0(u_d0), .Umbral_D1(u_d1)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_L = 1'b0; init = 1'b1;
        u_vc0_in = 4'd0; u_vc1_in = 4'd0; u_d0_in = 4'd5; u_d1_in = 4'd3;
        {e_vc0, e_vc1, e_d0, e_d1} = 4'b1111;
        {er_vc0, er_vc1, er_d0, er_d1} = 4'b0000;
        tick(2);
        vectors++; if (state !== 3'b000) begin miscompares++; $display("FAIL reset_state got %b want 000", state); end
        vectors++; if ({init_fifo, idle_out, active_out, error_out} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags got %b want 0000", {init_fifo, idle_out, active_out, error_out}); end
        vectors++; if ({u_vc0, u_vc1, u_d0, u_d1, error_src} !== 20'h0) begin miscompares++; $display("FAIL reset_regs got %h want 00000", {u_vc0, u_vc1, u_d0, u_d1, error_src}); end
        reset_L = 1'b1;
        tick();
        vectors++; if (state !== 3'b001) begin miscompares++; $display("FAIL bringup_init got %b want 001", state); end
        vectors++; if (init_fifo !== 1'b1) begin miscompares++; $display("FAIL init_fifo got %b want 1", init_fifo); end
        tick(2);
        vectors++; if (u_d0 !== 4'd5 || u_d1 !== 4'd3) begin miscompares++; $display("FAIL umbral_d got %0d/%0d want 5/3", u_d0, u_d1); end
        vectors++; if (state !== 3'b001) begin miscompares++; $display("FAIL init_hold got %b want 001", state); end
    endtask

    task automatic test_clamp;
        u_vc0_in = 4'd15; u_vc1_in = 4'd7; init = 1'b0;
        tick();
        vectors++; if (state !== 3'b010 || idle_out !== 1'b1 || init_fifo !== 1'b0) begin miscompares++; $display("FAIL init_to_idle got st=%b idle=%b initf=%b want 010/1/0", state, idle_out, init_fifo); end
        vectors++; if (u_vc0 !== 4'd7 || u_vc1 !== 4'd7) begin miscompares++; $display("FAIL clamp got %0d/%0d want 7/7", u_vc0, u_vc1); end
        u_vc0_in = 4'd1; u_vc1_in = 4'd1; u_d0_in = 4'd1; u_d1_in = 4'd1;
        tick(2);
        vectors++; if ({u_vc0, u_vc1, u_d0, u_d1} !== {4'd7, 4'd7, 4'd5, 4'd3}) begin miscompares++; $display("FAIL frozen got %h want 7753", {u_vc0, u_vc1, u_d0, u_d1}); end
    endtask

    task automatic test_activity;
        e_vc0 = 1'b0;
        tick();
        vectors++; if (state !== 3'b011 || active_out !== 1'b1 || idle_out !== 1'b0) begin miscompares++; $display("FAIL to_active got st=%b act=%b want 011/1", state, active_out); end
        tick(2);
        e_vc0 = 1'b1;
        tick();
        vectors++; if (state !== 3'b011) begin miscompares++; $display("FAIL debounce1 got %b want 011", state); end
        e_vc0 = 1'b0;
        tick();
        e_vc0 = 1'b1;
        tick();
        vectors++; if (state !== 3'b011) begin miscompares++; $display("FAIL counter_restart got %b want 011", state); end
        tick();
        vectors++; if (state !== 3'b010 || idle_out !== 1'b1 || active_out !== 1'b0) begin miscompares++; $display("FAIL back_to_idle got st=%b idle=%b want 010/1", state, idle_out); end
    endtask

    task automatic test_error;
        e_vc0 = 1'b0;
        tick();
        er_d1 = 1'b1;
        tick();
        vectors++; if (state !== 3'b100 || error_out !== 1'b1 || active_out !== 1'b0) begin miscompares++; $display("FAIL to_error got st=%b err=%b want 100/1", state, error_out); end
        vectors++; if (error_src !== 4'b1000) begin miscompares++; $display("FAIL src_entry got %b want 1000", error_src); end
        er_d1 = 1'b0; er_vc0 = 1'b1; e_vc0 = 1'b1;
        tick();
        vectors++; if (error_src !== 4'b1001) begin miscompares++; $display("FAIL src_accum got %b want 1001", error_src); end
        er_vc0 = 1'b0; e_vc0 = 1'b0;
        tick();
        e_vc0 = 1'b1;
        tick();
        vectors++; if (state !== 3'b100 || error_src !== 4'b1001) begin miscompares++; $display("FAIL error_sticky got st=%b src=%b want 100/1001", state, error_src); end
    endtask

    task automatic test_priority;
        init = 1'b1;
        tick();
        init = 1'b0;
        tick();
        vectors++; if (state !== 3'b010 || u_vc0 !== 4'd1) begin miscompares++; $display("FAIL recover_idle got st=%b vc0=%0d want 010/1", state, u_vc0); end
        er_d0 = 1'b1; init = 1'b1;
        tick();
        vectors++; if (state !== 3'b100 || error_src !== 4'b0100) begin miscompares++; $display("FAIL err_wins got st=%b src=%b want 100/0100", state, error_src); end
        er_d0 = 1'b0;
        tick();
        vectors++; if (state !== 3'b001 || error_src !== 4'b0000 || init_fifo !== 1'b1 || error_out !== 1'b0) begin miscompares++; $display("FAIL err_to_init got st=%b src=%b want 001/0000", state, error_src); end
        init = 1'b0;
        tick();
        vectors++; if (state !== 3'b010) begin miscompares++; $display("FAIL prio_idle got %b want 010", state); end
    endtask

    task automatic test_async_reset;
        e_vc0 = 1'b0;
        tick();
        vectors++; if (state !== 3'b011) begin miscompares++; $display("FAIL pre_reset_active got %b want 011", state); end
        #2 reset_L = 1'b0;
        #1;
        vectors++; if (state !== 3'b000 || {init_fifo, idle_out, active_out, error_out} !== 4'b0000) begin miscompares++; $display("FAIL async_reset got st=%b flags=%b want 000/0000", state, {init_fifo, idle_out, active_out, error_out}); end
        vectors++; if ({u_vc0, u_vc1, u_d0, u_d1, error_src} !== 20'h0) begin miscompares++; $display("FAIL async_clear got %h want 00000", {u_vc0, u_vc1, u_d0, u_d1, error_src}); end
        tick();
        vectors++; if (state !== 3'b000) begin miscompares++; $display("FAIL reset_held got %b want 000", state); end
        reset_L = 1'b1;
        tick();
        vectors++; if (state !== 3'b001) begin miscompares++; $display("FAIL rebringup got %b want 001", state); end
    endtask

    initial begin
        test_reset();
        test_clamp();
        test_activity();
        test_error();
        test_priority();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
